// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared types for the byte-wide memory bus arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      DONE  = 2'd3
   } arb_state;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DBG = 1'b1
   } requester;

   localparam int TO_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/mem_arb_rr.sv
// ---------------------------------------------------------------------------
// mem_arb_rr : two-way round-robin grant picker with last-grant memory. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic nrst,
   input  logic cpu_pend,
   input  logic dbg_pend,
   input  logic update,
   output logic grant
);

   requester r_last;

   always_comb begin
      grant = REQ_CPU;
      if (cpu_pend && dbg_pend) begin
         grant = (r_last == REQ_DBG) ? REQ_CPU : REQ_DBG;
      end else if (dbg_pend) begin
         grant = REQ_DBG;
      end
   end

   // Recording at grant time is equivalent to recording at completion: the
   // picker is only consulted again once the granted transaction has finished.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_last <= REQ_DBG;
      end else if (update) begin
         r_last <= requester'(grant);
      end
   end

endmodule

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter : shares a byte-wide memory bus between CPU and debug ports,
// splitting 16-bit accesses into two little-endian beats. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module memory_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        nrst,

   input  logic        cpu_read_en,
   input  logic        cpu_write_en,
   input  logic        cpu_dbl_byte_en,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_ack,

   input  logic        dbg_read_en,
   input  logic        dbg_write_en,
   input  logic        dbg_dbl_byte_en,
   input  logic [15:0] dbg_addr,
   input  logic [15:0] dbg_wdata,
   output logic [15:0] dbg_rdata,
   output logic        dbg_ack,

   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic [7:0]  bus_rdata,
   input  logic        bus_ack
);

   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

   arb_state              r_state;
   arb_state              w_next_state;
   logic                  r_grant;
   logic                  r_we;
   logic                  r_dbl;
   logic [15:0]           r_addr;
   logic [15:0]           r_wdata;
   logic [15:0]           r_rdata;
   logic                  r_err;
   logic [TO_CNT_W-1:0]   r_cnt;
   logic [15:0]           r_cpu_rdata;
   logic [15:0]           r_dbg_rdata;

   logic                  w_cpu_pend;
   logic                  w_dbg_pend;
   logic                  w_any_pend;
   logic                  w_take;
   logic                  w_grant;
   logic                  w_sel_we;
   logic                  w_sel_dbl;
   logic [15:0]           w_sel_addr;
   logic [15:0]           w_sel_wdata;
   logic                  w_in_beat;
   logic                  w_timeout;

   assign w_cpu_pend = cpu_read_en | cpu_write_en;
   assign w_dbg_pend = dbg_read_en | dbg_write_en;
   assign w_any_pend = w_cpu_pend | w_dbg_pend;
   assign w_take     = (r_state == IDLE) && w_any_pend;

   mem_arb_rr u_rr (
      .clk      (clk),
      .nrst     (nrst),
      .cpu_pend (w_cpu_pend),
      .dbg_pend (w_dbg_pend),
      .update   (w_take),
      .grant    (w_grant)
   );

   // A simultaneous read and write strobe is a write, so only write_en matters.
   assign w_sel_we    = (w_grant == REQ_DBG) ? dbg_write_en    : cpu_write_en;
   assign w_sel_dbl   = (w_grant == REQ_DBG) ? dbg_dbl_byte_en : cpu_dbl_byte_en;
   assign w_sel_addr  = (w_grant == REQ_DBG) ? dbg_addr        : cpu_addr;
   assign w_sel_wdata = (w_grant == REQ_DBG) ? dbg_wdata       : cpu_wdata;

   assign w_in_beat = (r_state == BEAT0) || (r_state == BEAT1);
   assign w_timeout = w_in_beat && !bus_ack && (r_cnt == TO_LAST);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_any_pend) begin
               w_next_state = BEAT0;
            end
         end
         BEAT0: begin
            if (bus_ack) begin
               w_next_state = r_dbl ? BEAT1 : DONE;
            end else if (w_timeout) begin
               w_next_state = DONE;
            end
         end
         BEAT1: begin
            if (bus_ack || w_timeout) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_grant     <= REQ_CPU;
         r_we        <= 1'b0;
         r_dbl       <= 1'b0;
         r_addr      <= 16'h0000;
         r_wdata     <= 16'h0000;
         r_rdata     <= 16'h0000;
         r_err       <= 1'b0;
         r_cnt       <= '0;
         r_cpu_rdata <= 16'h0000;
         r_dbg_rdata <= 16'h0000;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_pend) begin
                  r_grant <= w_grant;
                  r_we    <= w_sel_we;
                  r_dbl   <= w_sel_dbl;
                  r_addr  <= w_sel_addr;
                  r_wdata <= w_sel_wdata;
                  r_rdata <= 16'h0000;
                  r_err   <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            BEAT0, BEAT1: begin
               if (bus_ack) begin
                  r_cnt <= '0;
                  if (!r_we) begin
                     if (r_state == BEAT0) begin
                        r_rdata[7:0] <= bus_rdata;
                     end else begin
                        r_rdata[15:8] <= bus_rdata;
                     end
                  end
               end else if (w_timeout) begin
                  r_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               if (r_grant == REQ_CPU) begin
                  r_cpu_rdata <= r_rdata;
               end else begin
                  r_dbg_rdata <= r_rdata;
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   // Bus outputs decode only registered state so they never follow req inputs.
   assign bus_req   = w_in_beat;
   assign bus_we    = w_in_beat && r_we;
   assign bus_addr  = (r_state == BEAT1) ? (r_addr + 16'd1) :
                      (r_state == BEAT0) ? r_addr : 16'h0000;
   assign bus_wdata = (r_state == BEAT1) ? r_wdata[15:8] :
                      (r_state == BEAT0) ? r_wdata[7:0] : 8'h00;

   assign cpu_ack   = (r_state == DONE) && (r_grant == REQ_CPU);
   assign dbg_ack   = (r_state == DONE) && (r_grant == REQ_DBG);
   assign bus_err   = (r_state == DONE) && r_err;

   assign cpu_rdata = cpu_ack ? r_rdata : r_cpu_rdata;
   assign dbg_rdata = dbg_ack ? r_rdata : r_dbg_rdata;

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter : directed self-checking bench for memory_arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_memory_arbiter;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        cpu_read_en = 1'b0, cpu_write_en = 1'b0, cpu_dbl_byte_en = 1'b0;
   logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
   logic [15:0] cpu_rdata;
   logic        cpu_ack;
   logic        dbg_read_en = 1'b0, dbg_write_en = 1'b0, dbg_dbl_byte_en = 1'b0;
   logic [15:0] dbg_addr = 16'h0, dbg_wdata = 16'h0;
   logic [15:0] dbg_rdata;
   logic        dbg_ack;
   logic        bus_err, bus_req, bus_we, bus_ack;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata, bus_rdata;

   logic [7:0]  mem [0:65535];
   logic [7:0]  waits = 8'd0;
   logic        ack_en = 1'b1;
   logic [7:0]  wcnt = 8'd0;
   int          cyc = 0;
   int          nb = 0;
   int          req_cycles = 0;
   logic [15:0] log_addr [0:63];
   logic [7:0]  log_wd   [0:63];
   logic        log_we   [0:63];

   int npass = 0;
   int ntotal = 0;

   memory_arbiter #(.TIMEOUT(4)) dut (
      .clk             (clk),
      .nrst            (nrst),
      .cpu_read_en     (cpu_read_en),
      .cpu_write_en    (cpu_write_en),
      .cpu_dbl_byte_en (cpu_dbl_byte_en),
      .cpu_addr        (cpu_addr),
      .cpu_wdata       (cpu_wdata),
      .cpu_rdata       (cpu_rdata),
      .cpu_ack         (cpu_ack),
      .dbg_read_en     (dbg_read_en),
      .dbg_write_en    (dbg_write_en),
      .dbg_dbl_byte_en (dbg_dbl_byte_en),
      .dbg_addr        (dbg_addr),
      .dbg_wdata       (dbg_wdata),
      .dbg_rdata       (dbg_rdata),
      .dbg_ack         (dbg_ack),
      .bus_err         (bus_err),
      .bus_req         (bus_req),
      .bus_we          (bus_we),
      .bus_addr        (bus_addr),
      .bus_wdata       (bus_wdata),
      .bus_rdata       (bus_rdata),
      .bus_ack         (bus_ack)
   );

   always #5 clk = ~clk;

   // Memory model: acks after `waits` wait states, serves reads from mem.
   assign bus_ack   = bus_req && ack_en && (wcnt == waits);
   assign bus_rdata = mem[bus_addr];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!bus_req || bus_ack) wcnt <= 8'd0;
      else                     wcnt <= wcnt + 8'd1;
      if (bus_req) req_cycles <= req_cycles + 1;
      if (bus_req && bus_ack && nb < 64) begin
         log_addr[nb] <= bus_addr;
         log_wd[nb]   <= bus_wdata;
         log_we[nb]   <= bus_we;
         nb           <= nb + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One request from CPU (sel=0) or debug (sel=1); latency counts from the
   // IDLE cycle that sees the request to the ack cycle (-1 if no ack).
   task automatic txn(input logic sel, input logic we, input logic dbl,
                      input logic [15:0] addr, input logic [15:0] wdata,
                      output int lat, output logic [15:0] rd, output logic err);
      int c0;
      @(posedge clk); #1;
      if (!sel) begin
         cpu_read_en = !we; cpu_write_en = we; cpu_dbl_byte_en = dbl;
         cpu_addr = addr; cpu_wdata = wdata;
      end else begin
         dbg_read_en = !we; dbg_write_en = we; dbg_dbl_byte_en = dbl;
         dbg_addr = addr; dbg_wdata = wdata;
      end
      c0 = cyc; lat = -1; rd = 16'hxxxx; err = 1'bx;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (sel ? dbg_ack : cpu_ack) begin
            lat = cyc - c0;
            rd  = sel ? dbg_rdata : cpu_rdata;
            err = bus_err;
            break;
         end
      end
      @(posedge clk); #1;
      cpu_read_en = 0; cpu_write_en = 0; dbg_read_en = 0; dbg_write_en = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, base, rbase, c0, k;
      logic [15:0] rd;
      logic err;
      int who [0:3];
      int when [0:3];
      logic [15:0] data [0:3];
      logic [15:0] cpu_hold;

      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      mem[16'h1234] = 8'hAB;
      mem[16'h2000] = 8'h34;
      mem[16'h2001] = 8'h12;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_bus_req",   {31'd0, bus_req},   32'd0);
      check("rst_bus_we",    {31'd0, bus_we},    32'd0);
      check("rst_bus_addr",  {16'd0, bus_addr},  32'd0);
      check("rst_bus_wdata", {24'd0, bus_wdata}, 32'd0);
      check("rst_cpu_ack",   {31'd0, cpu_ack},   32'd0);
      check("rst_dbg_ack",   {31'd0, dbg_ack},   32'd0);
      check("rst_bus_err",   {31'd0, bus_err},   32'd0);
      check("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
      check("rst_dbg_rdata", {16'd0, dbg_rdata}, 32'd0);
      @(posedge clk); #1 nrst = 1'b1;

      // CPU 8-bit read, zero wait
      base = nb;
      txn(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, lat, rd, err);
      check("rd8_latency", lat, 32'd2);
      check("rd8_rdata",   {16'd0, rd}, 32'h00AB);
      check("rd8_err",     {31'd0, err}, 32'd0);
      check("rd8_nbeats",  nb - base, 32'd1);
      check("rd8_addr",    {16'd0, log_addr[base]}, 32'h1234);
      check("rd8_we",      {31'd0, log_we[base]}, 32'd0);

      // CPU 16-bit write across the address wrap
      base = nb;
      txn(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF, lat, rd, err);
      check("wr16_latency", lat, 32'd3);
      check("wr16_nbeats",  nb - base, 32'd2);
      check("wr16_addr0",   {16'd0, log_addr[base]},   32'hFFFF);
      check("wr16_wd0",     {24'd0, log_wd[base]},     32'hEF);
      check("wr16_we0",     {31'd0, log_we[base]},     32'd1);
      check("wr16_addr1",   {16'd0, log_addr[base+1]}, 32'h0000);
      check("wr16_wd1",     {24'd0, log_wd[base+1]},   32'hBE);
      check("wr16_we1",     {31'd0, log_we[base+1]},   32'd1);

      // Debug 16-bit read with 3 wait states per beat (last cycle before timeout)
      waits = 8'd3;
      base = nb;
      txn(1'b1, 1'b0, 1'b1, 16'h2000, 16'h0000, lat, rd, err);
      check("dbg16_latency", lat, 32'd9);
      check("dbg16_rdata",   {16'd0, rd}, 32'h1234);
      check("dbg16_err",     {31'd0, err}, 32'd0);
      check("dbg16_nbeats",  nb - base, 32'd2);
      waits = 8'd0;

      // Simultaneous requests held continuously: grants alternate
      @(posedge clk); #1;
      cpu_read_en = 1; cpu_dbl_byte_en = 0; cpu_addr = 16'h1234;
      dbg_read_en = 1; dbg_dbl_byte_en = 0; dbg_addr = 16'h2000;
      c0 = cyc; k = 0; cpu_hold = 16'h0;
      for (int i = 0; i < 40 && k < 4; i++) begin
         @(negedge clk);
         if (cpu_ack || dbg_ack) begin
            who[k]  = dbg_ack ? 1 : 0;
            when[k] = cyc - c0;
            data[k] = dbg_ack ? dbg_rdata : cpu_rdata;
            if (k == 1) cpu_hold = cpu_rdata;
            k++;
         end
      end
      @(posedge clk); #1;
      cpu_read_en = 0; dbg_read_en = 0;
      check("rr_count",  k, 32'd4);
      check("rr_grant0", who[0], 32'd0);
      check("rr_grant1", who[1], 32'd1);
      check("rr_grant2", who[2], 32'd0);
      check("rr_grant3", who[3], 32'd1);
      check("rr_time0",  when[0], 32'd2);
      check("rr_time3",  when[3], 32'd11);
      check("rr_cpu_data", {16'd0, data[0]}, 32'h00AB);
      check("rr_dbg_data", {16'd0, data[1]}, 32'h0034);
      check("rr_cpu_hold", {16'd0, cpu_hold}, 32'h00AB);

      // Timeout: bus never acks
      ack_en = 1'b0;
      base = nb; rbase = req_cycles;
      txn(1'b0, 1'b0, 1'b1, 16'h4000, 16'h0000, lat, rd, err);
      check("to_latency",  lat, 32'd5);
      check("to_err",      {31'd0, err}, 32'd1);
      check("to_rdata",    {16'd0, rd}, 32'h0000);
      check("to_req_cyc",  req_cycles - rbase, 32'd4);
      check("to_nbeats",   nb - base, 32'd0);
      ack_en = 1'b1;

      // Reset during BEAT1
      waits = 8'd2;
      @(posedge clk); #1;
      cpu_read_en = 1; cpu_dbl_byte_en = 1; cpu_addr = 16'h2000;
      c0 = cyc;
      @(negedge clk);
      while (cyc < c0 + 4) @(negedge clk);
      check("rb_beat1_req",  {31'd0, bus_req},  32'd1);
      check("rb_beat1_addr", {16'd0, bus_addr}, 32'h2001);
      #1 nrst = 1'b0;
      #1;
      check("rb_req_drop",   {31'd0, bus_req}, 32'd0);
      check("rb_no_ack",     {31'd0, cpu_ack}, 32'd0);
      @(negedge clk);
      check("rb_hold_req",   {31'd0, bus_req}, 32'd0);
      check("rb_hold_ack",   {31'd0, cpu_ack}, 32'd0);
      check("rb_rdata_clr",  {16'd0, cpu_rdata}, 32'd0);
      @(posedge clk); #1 nrst = 1'b1;
      c0 = cyc; base = nb; lat = -1; rd = 16'hxxxx;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (cpu_ack) begin
            lat = cyc - c0;
            rd  = cpu_rdata;
            break;
         end
      end
      @(posedge clk); #1;
      cpu_read_en = 0; cpu_dbl_byte_en = 0;
      waits = 8'd0;
      check("rb_restart_lat",   lat, 32'd7);
      check("rb_restart_rdata", {16'd0, rd}, 32'h1234);
      check("rb_restart_addr0", {16'd0, log_addr[base]}, 32'h2000);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single byte-wide external memory bus between the CPU control unit and a secondary requester (debug/loader port). Each granted request is sequenced as one or two byte beats on the bus: 16-bit accesses are split into two beats, little-endian. The requester receives a single completion pulse with assembled read data. The block sits between the control unit's memory port and the chip-level SRAM/wishbone bridge.

## Interface
Parameters:
- TIMEOUT, 255: bus_ack wait limit per beat, in cycles (1..255).

Ports:
- clk  in  1  system clock; all state rises on posedge.
- nrst  in  1  asynchronous active-low reset.
- cpu_read_en, cpu_write_en  in  1 each  CPU request strobes; held until cpu_ack.
- cpu_dbl_byte_en  in  1  1 = 16-bit access, 0 = 8-bit access.
- cpu_addr  in  16  byte address.
- cpu_wdata  in  16  write data; low byte only for 8-bit accesses.
- cpu_rdata  out  16  read data; valid in the cpu_ack cycle, held until the next CPU completion.
- cpu_ack  out  1  one-cycle completion pulse.
- dbg_read_en, dbg_write_en, dbg_dbl_byte_en, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same meaning and widths as the CPU set.
- bus_err  out  1  pulses with the ack when a beat timed out.
- bus_req  out  1  beat request to memory.
- bus_we  out  1  beat is a write.
- bus_addr  out  16  beat byte address.
- bus_wdata  out  8  beat write byte.
- bus_rdata  in  8  beat read byte; sampled when bus_ack=1.
- bus_ack  in  1  beat complete.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE: pending request = read_en|write_en.
  - Only one requester pending: grant it.
  - Both pending: grant the one not granted last (round-robin). last_grant resets to dbg, so CPU wins the first tie.
  - Latch addr, wdata, we, dbl, grant; go to BEAT0.
- read_en and write_en both high: treated as a write.
- BEAT0:
  - bus_req=1, bus_addr=addr, bus_wdata=wdata[7:0].
  - On bus_ack: read captures bus_rdata into rdata[7:0]. If dbl, go to BEAT1, else go to DONE.
- BEAT1:
  - bus_addr=addr+1 (16-bit wrap: 0xFFFF→0x0000), bus_wdata=wdata[15:8].
  - On bus_ack: read captures rdata[15:8]; go to DONE.
- DONE:
  - Pulse the granted requester's ack and drive its rdata.
  - Update last_grant; return to IDLE.
- 8-bit reads zero-extend: rdata[15:8]=0.
- Timeout: per-beat counter clears on beat entry. After TIMEOUT cycles without bus_ack, go to DONE with bus_err=1. Bytes not received read as 0, and no further beat is issued.
- Requests are sampled only in IDLE. A requester still asserting in the cycle after its ack is treated as a new request.
- Changes to a requester's inputs after grant are ignored until DONE.
- Reset (any time): state=IDLE, bus_req=0 immediately (async), all transactions discarded.

## Timing
- Reset values: bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, cpu_ack=0, dbg_ack=0, bus_err=0, cpu_rdata=0, dbg_rdata=0, last_grant=dbg.
- All bus_* outputs are registered/state-decoded and do not depend combinationally on the req inputs.
- Zero-wait bus (bus_ack high in the first beat cycle):
  - Request seen in IDLE at cycle N.
  - 8-bit access: BEAT0 at N+1, ack at N+2.
  - 16-bit access: BEAT1 at N+2, ack at N+3.
- Wait states add one cycle each. Minimum spacing between back-to-back transactions is one IDLE cycle.
- bus_ack outside BEAT0/BEAT1 is ignored.

## Structure
- Shared package mem_arb_pkg holds:
  - typedef arb_state {IDLE, BEAT0, BEAT1, DONE};
  - typedef requester {REQ_CPU, REQ_DBG};
  - localparam for TIMEOUT width (8).
- One sub-module, mem_arb_rr: a 2-way round-robin grant picker with a last_grant register. Inputs: two pending lines plus an update strobe. Output: grant.

## Test plan
- Reset, then CPU 8-bit read of 0x1234 with bus_rdata=0xAB and immediate ack → one BEAT0 beat at 0x1234, cpu_rdata=0x00AB, cpu_ack 2 cycles after request.
- CPU 16-bit write 0xBEEF to 0xFFFF → beats (0xFFFF, 0xEF) then (0x0000, 0xBE), bus_we=1 on both, single cpu_ack.
- CPU and dbg requesting simultaneously, repeatedly, with 8-bit reads → grants alternate CPU, dbg, CPU, dbg.
- Dbg 16-bit read with 3 wait states per beat, bytes 0x34 and 0x12 → dbg_rdata=0x1234, ack at request+9.
- TIMEOUT=4 with bus_ack held low → ack 4 cycles after BEAT0 entry, bus_err=1, rdata=0x0000, no BEAT1.
- nrst low during BEAT1 → bus_req drops in the same cycle with no ack. After release, a pending CPU request restarts from BEAT0.
